// File: rtl/ahb_flash_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : ahb_flash_sequencer_if
// Brief  : AHB-Lite slave-side signal bundle for the flash sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
interface ahb_flash_sequencer_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface
`default_nettype wire

// File: rtl/ahb_flash_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ahb_flash_sequencer
// Brief  : AHB-Lite slave running a full single-bit SPI flash command in HW.
// Rev    : 1.0 - initial release
// ============================================================================
module ahb_flash_sequencer #(
  parameter logic [7:0]  DIV_RESET   = 8'd1,
  parameter logic [7:0]  POLL_OPCODE = 8'h05,
  parameter int          BUSY_BIT    = 0,
  parameter logic [15:0] POLL_LIMIT  = 16'hFFFF
) (
  input  wire logic            HCLK,
  input  wire logic            HRESETn,
  ahb_flash_sequencer_if.slave ahb,
  output logic                 fm_sck,
  output logic                 fm_ce_n,
  input  wire logic [3:0]      fm_din,
  output logic [3:0]           fm_dout,
  output logic [3:0]           fm_douten
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CS_SETUP    = 3'd1,
    SHIFT       = 3'd2,
    CS_HOLD     = 3'd3,
    CS_GAP      = 3'd4,
    POLL_DECIDE = 3'd5
  } state_t;

  // Bus-side registers
  logic        r_wr_pend;
  logic [2:0]  r_aoff;
  logic [31:0] r_cmd;
  logic [23:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_clkdiv;
  logic        r_done, r_err_busy, r_err_to;

  // Sequencer registers
  state_t      r_state;
  logic        r_busy, r_ce_n, r_sck, r_mosi, r_phase;
  logic [8:0]  r_cnt;
  logic [6:0]  r_bitn, r_nbits, r_hdr;
  logic [63:0] r_tx;
  logic [7:0]  r_rxb, r_sr;
  logic        r_rx_en, r_polling;
  logic [15:0] r_pollcnt;
  logic [31:0] r_rdata;

  logic        w_cmd_wr, w_start, w_cnt_done, w_gap_end, w_poll_stop;
  logic        w_set_done, w_set_to;
  logic [2:0]  w_clr, w_nb;
  logic [6:0]  w_nbits, w_d;
  logic [8:0]  w_div9;
  logic [31:0] w_data32;
  logic [63:0] w_tx;
  logic [7:0]  w_rxb_next;
  logic        w_unused;

  assign w_cmd_wr   = r_wr_pend && (r_aoff == 3'd0);
  assign w_start    = w_cmd_wr && !r_busy;
  assign w_clr      = (r_wr_pend && r_aoff == 3'd4) ? ahb.HWDATA[3:1] : 3'b000;
  assign w_div9     = {1'b0, r_clkdiv};
  assign w_cnt_done = (r_cnt == 9'd0);
  assign w_gap_end  = (r_state == CS_GAP) && w_cnt_done;
  assign w_poll_stop = r_polling && (!r_sr[BUSY_BIT] || r_pollcnt >= POLL_LIMIT);
  assign w_set_done = (w_gap_end && !r_cmd[13]) || ((r_state == POLL_DECIDE) && w_poll_stop);
  assign w_set_to   = (r_state == POLL_DECIDE) && r_polling && r_sr[BUSY_BIT] &&
                      (r_pollcnt >= POLL_LIMIT);

  // Outgoing frame is left-aligned: opcode, optional address, then byte 0 first
  assign w_nb     = (ahb.HWDATA[11:9] > 3'd4) ? 3'd4 : ahb.HWDATA[11:9];
  assign w_nbits  = 7'd8 + (ahb.HWDATA[8] ? 7'd24 : 7'd0) + {1'b0, w_nb, 3'b000};
  assign w_data32 = ahb.HWDATA[12] ? 32'h0 :
                    {r_wdata[7:0], r_wdata[15:8], r_wdata[23:16], r_wdata[31:24]};
  assign w_tx     = ahb.HWDATA[8] ? {ahb.HWDATA[7:0], r_addr, w_data32}
                                  : {ahb.HWDATA[7:0], w_data32, 24'h0};
  assign w_d        = r_bitn - r_hdr;
  assign w_rxb_next = {r_rxb[6:0], fm_din[1]};

  assign fm_sck        = r_sck;
  assign fm_ce_n       = r_ce_n;
  assign fm_dout       = {3'b000, r_mosi};
  assign fm_douten     = {3'b000, ~r_ce_n};
  assign ahb.HREADYOUT = 1'b1;
  assign w_unused = ^{ahb.HSIZE, ahb.HADDR[31:5], ahb.HADDR[1:0], ahb.HTRANS[0],
                      fm_din[3:2], fm_din[0], w_d[6:5]};

  always_comb begin
    ahb.HRDATA = 32'h0;
    case (r_aoff)
      3'd0:    ahb.HRDATA = r_cmd;
      3'd1:    ahb.HRDATA = {8'h00, r_addr};
      3'd2:    ahb.HRDATA = r_wdata;
      3'd3:    ahb.HRDATA = r_rdata;
      3'd4:    ahb.HRDATA = {16'h0, r_sr, 4'h0, r_err_to, r_err_busy, r_done, r_busy};
      3'd5:    ahb.HRDATA = {24'h0, r_clkdiv};
      default: ahb.HRDATA = 32'h0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_pend  <= 1'b0;
      r_aoff     <= 3'd0;
      r_cmd      <= 32'h0;
      r_addr     <= 24'h0;
      r_wdata    <= 32'h0;
      r_clkdiv   <= DIV_RESET;
      r_done     <= 1'b0;
      r_err_busy <= 1'b0;
      r_err_to   <= 1'b0;
    end else begin
      if (ahb.HSEL && ahb.HREADY && ahb.HTRANS[1]) begin
        r_wr_pend <= ahb.HWRITE;
        r_aoff    <= ahb.HADDR[4:2];
      end else begin
        r_wr_pend <= 1'b0;
      end
      if (w_start) r_cmd <= ahb.HWDATA;
      if (r_wr_pend) begin
        case (r_aoff)
          3'd1:    r_addr  <= ahb.HWDATA[23:0];
          3'd2:    r_wdata <= ahb.HWDATA;
          3'd5:    if (!r_busy) r_clkdiv <= ahb.HWDATA[7:0];
          default: ;
        endcase
      end
      // Set terms are OR-ed in last so a coincident W1C loses
      r_done     <= (r_done     & ~w_clr[0]) | w_set_done;
      r_err_busy <= (r_err_busy & ~w_clr[1]) | (w_cmd_wr & r_busy);
      r_err_to   <= (r_err_to   & ~w_clr[2]) | w_set_to;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_ce_n    <= 1'b1;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_phase   <= 1'b0;
      r_cnt     <= 9'd0;
      r_bitn    <= 7'd0;
      r_nbits   <= 7'd0;
      r_hdr     <= 7'd0;
      r_tx      <= 64'h0;
      r_rxb     <= 8'h0;
      r_sr      <= 8'h0;
      r_rx_en   <= 1'b0;
      r_polling <= 1'b0;
      r_pollcnt <= 16'h0;
      r_rdata   <= 32'h0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_state   <= CS_SETUP;
          r_busy    <= 1'b1;
          r_ce_n    <= 1'b0;
          r_cnt     <= w_div9;
          r_tx      <= w_tx;
          r_nbits   <= w_nbits;
          r_hdr     <= ahb.HWDATA[8] ? 7'd32 : 7'd8;
          r_rx_en   <= ahb.HWDATA[12];
          r_polling <= 1'b0;
          r_pollcnt <= 16'h0;
          r_rdata   <= 32'h0;
        end
        CS_SETUP: if (w_cnt_done) begin
          r_state <= SHIFT;
          r_phase <= 1'b0;
          r_cnt   <= w_div9;
          r_bitn  <= 7'd0;
          r_mosi  <= r_tx[63];
          r_tx    <= {r_tx[62:0], 1'b0};
        end else begin
          r_cnt <= r_cnt - 9'd1;
        end
        SHIFT: if (!w_cnt_done) begin
          r_cnt <= r_cnt - 9'd1;
        end else if (!r_phase) begin
          r_sck   <= 1'b1;
          r_phase <= 1'b1;
          r_cnt   <= w_div9;
          if (r_rx_en && r_bitn >= r_hdr) begin
            r_rxb <= w_rxb_next;
            if (w_d[2:0] == 3'd7) begin
              if (r_polling) r_sr <= w_rxb_next;
              else           r_rdata[{w_d[4:3], 3'b000} +: 8] <= w_rxb_next;
            end
          end
        end else begin
          r_sck <= 1'b0;
          r_cnt <= w_div9;
          if (r_bitn == r_nbits - 7'd1) begin
            r_state <= CS_HOLD;
            r_mosi  <= 1'b0;
          end else begin
            r_phase <= 1'b0;
            r_bitn  <= r_bitn + 7'd1;
            r_mosi  <= r_tx[63];
            r_tx    <= {r_tx[62:0], 1'b0};
          end
        end
        CS_HOLD: if (w_cnt_done) begin
          r_state <= CS_GAP;
          r_ce_n  <= 1'b1;
          r_cnt   <= {r_clkdiv, 1'b1};
        end else begin
          r_cnt <= r_cnt - 9'd1;
        end
        CS_GAP: if (w_cnt_done) begin
          if (r_cmd[13]) begin
            r_state <= POLL_DECIDE;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end else begin
          r_cnt <= r_cnt - 9'd1;
        end
        POLL_DECIDE: if (w_poll_stop) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_state   <= CS_SETUP;
          r_ce_n    <= 1'b0;
          r_cnt     <= w_div9;
          r_tx      <= {POLL_OPCODE, 56'h0};
          r_nbits   <= 7'd16;
          r_hdr     <= 7'd8;
          r_rx_en   <= 1'b1;
          r_polling <= 1'b1;
          r_pollcnt <= r_pollcnt + 16'h1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
